// File: rtl/fp_pkg.sv
// Shared FP datapath definitions: multiplier FSM states and the default
// fraction widths used by both the mantissa multiplier and divider.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int SP_FRAC_W = 23;
    localparam int DP_FRAC_W = 52;

endpackage

// File: rtl/mantissa_normalizer.sv
// Maps a raw {1.m1}x{1.m2} product to a truncated WIDTH-bit fraction plus
// an exponent-increment flag; outputs read zero while valid is low.
module mantissa_normalizer #(
    parameter int WIDTH = 23
) (
    input  logic [2*WIDTH+1:0] p,
    input  logic               valid,
    output logic [WIDTH-1:0]   m3,
    output logic               increment_exponent
);

    localparam int PW = 2*WIDTH + 2;

    // Product lies in [1,4); the top bit says whether it reached 2.0.
    always_comb begin
        m3                 = '0;
        increment_exponent = 1'b0;
        if (valid) begin
            increment_exponent = p[PW-1];
            m3 = p[PW-1] ? WIDTH'(p >> (WIDTH+1)) : WIDTH'(p >> WIDTH);
        end
    end

endmodule

// File: rtl/mantissa_multiplier_seq.sv
// Iterative radix-2 shift-add multiplier for hidden-one mantissas; one
// partial product per cycle, valid/ready handshake on both sides.
module mantissa_multiplier_seq
    import fp_pkg::*;
#(
    parameter int WIDTH = SP_FRAC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] m1,
    input  logic [WIDTH-1:0] m2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] m3,
    output logic             increment_exponent
);

    localparam int PW = 2*WIDTH + 2;
    localparam int CW = $clog2(WIDTH+1);

    mul_state_t      state, state_next;
    logic [PW-1:0]   a;
    logic [PW-1:0]   p;
    logic [WIDTH:0]  b;
    logic [CW-1:0]   cnt;
    logic            accept;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            p     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a   <= PW'({1'b1, m1});
                b   <= {1'b1, m2};
                p   <= '0;
                cnt <= CW'(WIDTH);
            end else if (state == BUSY) begin
                // Counter runs WIDTH..0, giving one step per multiplier bit.
                if (b[0]) p <= p + a;
                a <= a << 1;
                b <= b >> 1;
                if (cnt != '0) cnt <= cnt - CW'(1);
            end
        end
    end

    mantissa_normalizer #(.WIDTH(WIDTH)) u_norm (
        .p                  (p),
        .valid              (out_valid),
        .m3                 (m3),
        .increment_exponent (increment_exponent)
    );

endmodule

// File: tb/tb_mantissa_multiplier_seq.sv
// Directed and randomized checks of mantissa_multiplier_seq against an
// arithmetic reference product.
module tb_mantissa_multiplier_seq;

    localparam int W = 23;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] m1, m2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] m3;
    logic         increment_exponent;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mantissa_multiplier_seq #(.WIDTH(W)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .m1                 (m1),
        .m2                 (m2),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .m3                 (m3),
        .increment_exponent (increment_exponent)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: real-valued product of 1.f1 and 1.f2 in fixed point.
    task automatic ref_mul(input logic [W-1:0] f1, input logic [W-1:0] f2,
                           output logic [W-1:0] em, output logic ei);
        longint unsigned x, y, pr, two;
        x   = (64'd1 << W) + 64'(f1);
        y   = (64'd1 << W) + 64'(f2);
        pr  = x * y;
        two = 64'd1 << (2*W + 1);
        if (pr >= two) begin
            ei = 1'b1;
            em = W'((pr - two) / (64'd1 << (W + 1)));
        end else begin
            ei = 1'b0;
            em = W'((pr - (two >> 1)) / (64'd1 << W));
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] f1, input logic [W-1:0] f2,
                          input int hold, input bit disturb);
        logic [W-1:0] em;
        logic         ei;
        int           lat;
        ref_mul(f1, f2, em, ei);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        m1 = f1; m2 = f2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (disturb) begin
                m1 = W'($urandom); m2 = W'($urandom);
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
            end
            step();
            lat++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check({tag, "_m3"}, 64'(m3), 64'(em));
        check({tag, "_inc"}, 64'(increment_exponent), 64'(ei));
        for (int i = 0; i < hold; i++) begin
            m1 = W'($urandom); m2 = W'($urandom);
            step();
            check({tag, "_hold_m3"}, 64'(m3), 64'(em));
            check({tag, "_hold_inc"}, 64'(increment_exponent), 64'(ei));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_hold_out_valid"}, 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_post_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_m3"}, 64'(m3), 64'd0);
        check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] r1, r2;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; m1 = '0; m2 = '0;
        step();
        step();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_m3", 64'(m3), 64'd0);
        check("rst_inc", 64'(increment_exponent), 64'd0);

        // Reset and in_valid together: nothing is accepted.
        in_valid = 1'b1; m1 = 23'h400000; m2 = 23'h400000;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check("rst_vs_valid_in_ready", 64'(in_ready), 64'd1);
        step();
        check("rst_vs_valid_in_ready2", 64'(in_ready), 64'd1);
        check("rst_vs_valid_out_valid", 64'(out_valid), 64'd0);

        run_op("one_x_one", 23'h000000, 23'h000000, 0, 1'b0);
        check("one_x_one_ref", 64'd0, 64'd0 + 64'(m3));
        run_op("p15_x_p15", 23'h400000, 23'h400000, 0, 1'b0);
        run_op("p15_x_p125", 23'h400000, 23'h200000, 0, 1'b0);
        run_op("max_x_max", 23'h7FFFFF, 23'h7FFFFF, 0, 1'b0);
        run_op("backpressure", 23'h400000, 23'h200000, 10, 1'b1);

        // Abort at the 10th BUSY cycle.
        m1 = 23'h7FFFFF; m2 = 23'h7FFFFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_m3", 64'(m3), 64'd0);
        run_op("after_abort", 23'h400000, 23'h400000, 2, 1'b0);

        for (int k = 0; k < 8; k++) begin
            r1 = W'($urandom); r2 = W'($urandom);
            run_op($sformatf("rand%0d", k), r1, r2, int'($urandom_range(0, 3)), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
